op_display_scanner: RTL and testbench
=====================================

// Module: op_display_scanner
// PURPOSE
//  Time-multiplexed seven-segment driver for the calculator operation field.
//  - Latches a 3-bit operation code on a load strobe.
//  - Renders the code's mnemonic across NUM_DIGITS common-anode digits, one digit lit per refresh slot.
//  - Sits between the operation-select logic and the board display pins; it replaces per-digit static decode.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned, 4..8; text occupies digits 3..0, digits >=4 always blank
//  REFRESH_DIV  50000  clk cycles per digit slot, >=2
//  BLINK_CYC    8      refresh frames (full scans) per blink half-period; used only with OPDISP_ERR_EN
// PORTS
//  clk       in   1           system clock, rising edge
//  reset     in   1           synchronous, active-high
//  op_in     in   3           operation code: 001 Add, 010 SUb, 100 MUL, 011 dIV; all other codes invalid
//  op_load   in   1           single-cycle strobe; op_in captured on this edge
//  seg_n     out  7           active-low segments, [6]=g .. [0]=a
//  an_n      out  NUM_DIGITS  active-low digit enables, one-hot-low; [0]=rightmost digit
//  op_valid  out  1           latched code is one of the four legal codes
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1):
//    - op_reg=000, prescaler=0, digit_idx=0.
//    - seg_n=7'h7F, an_n=all 1s, op_valid=0; blink phase=0.
//  - Prescaler: counts 0..REFRESH_DIV-1. tick=1 on the terminal count, then wraps to 0.
//  - digit_idx: on tick, increments; wraps NUM_DIGITS-1 -> 0. A full wrap is one frame.
//  - Outputs are registered; each reflects digit_idx/op_reg of the previous cycle (1-cycle latency).
//    - an_n = ~(1<<digit_idx).
//    - seg_n = glyph(op_reg, digit_idx).
//  - Text, digits 3,2,1,0 (left-justified):
//    - Add = A,d,d,blank
//    - SUb = S,U,b,blank
//    - MUL = n,n,U,L (M drawn as two n glyphs)
//    - dIV = d,I,U,blank
//  - Glyphs (seg_n gfedcba):
//    - A=0001000, d=0100001, S=0010010, U=1000001, b=0000011, n=0101011,
//    - L=1000111, I=1111001, E=0000110, r=0101111, blank=1111111.
//  - Invalid or 000 code -> all digits blank; op_valid=0.
//  - op_load: op_reg<=op_in and op_valid updated on the same edge.
//    - New text appears on the first output register update after the load (1 cycle).
//    - Prescaler and digit_idx are NOT disturbed; scan phase is continuous.
//  - op_load coincident with tick: both take effect; the next digit shows the new code.
//  - op_load held high for several cycles: the last captured value wins; no error.
//  - reset mid-scan overrides everything, including a simultaneous op_load.
// CONFIGURATION
//  - OPDISP_ERR_EN defined:
//    - Invalid nonzero codes show E,r,r,blank.
//    - This text blinks: the blink phase toggles every BLINK_CYC frames; phase=1 forces seg_n=blank.
//    - Blink counter resets to 0 on any op_load.
//    - op_valid=0 while in this state.
//    - Code 000 stays blank without blinking.
//  - OPDISP_ERR_EN undefined:
//    - All invalid codes are blank.
//    - Blink counter and BLINK_CYC logic are absent.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_CYC=2)
//  1. Reset for 3 cycles, release -> seg_n=7F, an_n=F; then an_n cycles E,D,B,7,E with a change every 4 clocks.
//  2. Load 001 -> op_valid=1 next cycle; when an_n=7, seg_n=0001000 (A); an_n=B/D -> 0100001; an_n=E -> 7F.
//  3. Load 100 coincident with tick -> next lit digit uses MUL glyphs; no skipped or repeated digit in the an_n sequence.
//  4. Load 111, macro off -> all digits seg_n=7F, op_valid=0.
//  5. Load 111, OPDISP_ERR_EN on -> an_n=7 shows 0000110 for 2 frames, then 7F for 2 frames, repeating.
//     A reload of 111 restarts the phase at visible.
//  6. Assert reset mid-frame while op_load=1 with 010 -> next cycle op_reg=000, an_n=F, seg_n=7F, prescaler=0.

Source files
------------

// File: rtl/op_display_scanner.sv
// Scanned seven-segment driver for the calculator operation mnemonic.
// Optional OPDISP_ERR_EN: invalid nonzero codes show a blinking "Err".
module op_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_CYC   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            op_in,
  input  logic                  op_load,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  op_valid
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);

  localparam logic [6:0] G_A   = 7'b0001000;
  localparam logic [6:0] G_D   = 7'b0100001;
  localparam logic [6:0] G_S   = 7'b0010010;
  localparam logic [6:0] G_U   = 7'b1000001;
  localparam logic [6:0] G_B   = 7'b0000011;
  localparam logic [6:0] G_N   = 7'b0101011;
  localparam logic [6:0] G_L   = 7'b1000111;
  localparam logic [6:0] G_I   = 7'b1111001;
  localparam logic [6:0] G_BLK = 7'b1111111;

  logic [PW-1:0]         r_presc;
  logic [DW-1:0]         r_digit;
  logic [2:0]            r_op;
  logic                  r_valid;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_tick, w_frame, w_hi, w_blank;
  logic [1:0]            w_pos;
  logic [6:0]            w_glyph;

  assign w_tick  = (r_presc == PW'(REFRESH_DIV-1));
  assign w_frame = w_tick && (r_digit == DW'(NUM_DIGITS-1));
  assign w_pos   = r_digit[1:0];

  // Text lives only in digits 3..0; anything further left is always dark.
  generate
    if (DW > 2) begin : g_hi
      assign w_hi = |r_digit[DW-1:2];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_digit <= w_frame ? '0 : r_digit + DW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= 3'b000;
      r_valid <= 1'b0;
    end else if (op_load) begin
      r_op    <= op_in;
      r_valid <= (op_in == 3'b001) || (op_in == 3'b010) ||
                 (op_in == 3'b100) || (op_in == 3'b011);
    end
  end

`ifdef OPDISP_ERR_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [6:0] G_E = 7'b0000110;
  localparam logic [6:0] G_R = 7'b0101111;

  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          w_err;

  // A load restarts the blink so fresh error text is visible immediately.
  always_ff @(posedge clk) begin
    if (reset || op_load) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_frame) begin
      if (r_bcnt == BW'(BLINK_CYC-1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  assign w_err   = (r_op == 3'b101) || (r_op == 3'b110) || (r_op == 3'b111);
  assign w_blank = w_hi || (w_err && r_phase);
`else
  assign w_blank = w_hi;
`endif

  always_comb begin
    w_glyph = G_BLK;
    case (r_op)
      3'b001: case (w_pos)
        2'd3:       w_glyph = G_A;
        2'd2, 2'd1: w_glyph = G_D;
        default:    w_glyph = G_BLK;
      endcase
      3'b010: case (w_pos)
        2'd3:    w_glyph = G_S;
        2'd2:    w_glyph = G_U;
        2'd1:    w_glyph = G_B;
        default: w_glyph = G_BLK;
      endcase
      3'b100: case (w_pos)
        2'd3, 2'd2: w_glyph = G_N;
        2'd1:       w_glyph = G_U;
        default:    w_glyph = G_L;
      endcase
      3'b011: case (w_pos)
        2'd3:    w_glyph = G_D;
        2'd2:    w_glyph = G_I;
        2'd1:    w_glyph = G_U;
        default: w_glyph = G_BLK;
      endcase
`ifdef OPDISP_ERR_EN
      3'b101, 3'b110, 3'b111: case (w_pos)
        2'd3:       w_glyph = G_E;
        2'd2, 2'd1: w_glyph = G_R;
        default:    w_glyph = G_BLK;
      endcase
`endif
      default: w_glyph = G_BLK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= G_BLK;
      r_an  <= '1;
    end else begin
      r_seg <= w_blank ? G_BLK : w_glyph;
      r_an  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_digit);
    end
  end

  assign seg_n    = r_seg;
  assign an_n     = r_an;
  assign op_valid = r_valid;
endmodule

// File: tb/tb_op_display_scanner.sv
// Random-stimulus bench for op_display_scanner against a cycle-count based model.
module tb_op_display_scanner;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BLK = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   op_in = 3'b000;
  logic         op_load = 1'b0;
  logic [6:0]   seg_n;
  logic [N-1:0] an_n;
  logic         op_valid;

  int n_err = 0;
  int n_chk = 0;

  // Model state: edges since reset, latched code, frames completed since last load.
  int         m_k = 0;
  logic [2:0] m_op = 3'b000;
  int         m_frames = 0;

  op_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_CYC(BLK)) dut (
    .clk(clk), .reset(reset), .op_in(op_in), .op_load(op_load),
    .seg_n(seg_n), .an_n(an_n), .op_valid(op_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_k);
    end
  endtask

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "A": return 7'b0001000;
      "d": return 7'b0100001;
      "S": return 7'b0010010;
      "U": return 7'b1000001;
      "b": return 7'b0000011;
      "n": return 7'b0101011;
      "L": return 7'b1000111;
      "I": return 7'b1111001;
      "E": return 7'b0000110;
      "r": return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit is_err(input logic [2:0] op);
`ifdef OPDISP_ERR_EN
    return op >= 3'd5;
`else
    return 1'b0;
`endif
  endfunction

  function automatic string text_of(input logic [2:0] op);
    case (op)
      3'b001: return "Add ";
      3'b010: return "SUb ";
      3'b100: return "nnUL";
      3'b011: return "dIU ";
      default: return is_err(op) ? "Err " : "    ";
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [2:0] op, input int d, input int frames);
    string s;
    s = text_of(op);
    if (d > 3) return 7'h7F;
    if (is_err(op) && ((frames / BLK) % 2 == 1)) return 7'h7F;
    return seg_of(s[3-d]);
  endfunction

  task automatic step(input logic rst, input logic ld, input logic [2:0] op);
    logic [6:0]   eseg;
    logic [N-1:0] ean;
    logic         evld;
    int           d;
    reset = rst; op_load = ld; op_in = op;
    @(posedge clk);
    #1;
    if (rst) begin
      eseg = 7'h7F;
      ean  = '1;
    end else begin
      d    = (m_k / DIV) % N;
      ean  = ~(N'(1) << d);
      eseg = exp_seg(m_op, d, m_frames);
    end
    if (rst) begin
      m_k = 0; m_op = 3'b000; m_frames = 0;
    end else begin
      m_k++;
      if (ld) begin
        m_op = op; m_frames = 0;
      end else if (m_k % (DIV*N) == 0) begin
        m_frames++;
      end
    end
    evld = (m_op == 3'b001) || (m_op == 3'b010) || (m_op == 3'b100) || (m_op == 3'b011);
    chk("seg_n", 32'(seg_n), 32'(eseg));
    chk("an_n", 32'(an_n), 32'(ean));
    chk("op_valid", 32'(op_valid), 32'(evld));
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 3'b000);
    repeat (20) step(1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b001);
    repeat (40) step(1'b0, 1'b0, 3'b000);
    // Load on a tick edge, then keep scanning.
    while (m_k % DIV != DIV-1) step(1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b100);
    repeat (40) step(1'b0, 1'b0, 3'b000);
    // Held load: last value wins.
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b111);
    repeat (150) step(1'b0, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b111);
    repeat (80) step(1'b0, 1'b0, 3'b000);
    // Reset mid-frame beats a simultaneous load.
    repeat (6) step(1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b010);
    repeat (30) step(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 700) == 0, ($urandom % 40) == 0, 3'($urandom_range(0, 7)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
